// File: rtl/fp_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_if
//   Groups the two pipeline-facing handshakes of the FP issue controller:
//   the EX-stage issue port (valid/ready plus instruction fields and flush)
//   and the WB write-port request (valid/ready plus register and data).
//
//   Signal names keep their controller-relative _i/_o suffixes so that the
//   controller body reads the same as its port list.
//
//   Modports
//     master : pipeline side (EX drives the issue, WB grants the write port)
//     slave  : controller side (fp_issue_ctrl)
// -----------------------------------------------------------------------------
interface fp_issue_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int RND_WIDTH  = 3
);
    // Issue port from EX
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic                  issue_op_i;
    logic [RND_WIDTH-1:0]  issue_rnd_i;
    logic [REG_WIDTH-1:0]  issue_rd_i;
    logic [DATA_WIDTH-1:0] issue_a_i;
    logic [DATA_WIDTH-1:0] issue_b_i;
    logic                  flush_i;

    // Write-port request to WB
    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [REG_WIDTH-1:0]  wb_reg_o;
    logic [DATA_WIDTH-1:0] wb_data_o;

    modport master (
        output issue_valid_i, issue_op_i, issue_rnd_i, issue_rd_i,
               issue_a_i, issue_b_i, flush_i, wb_ready_i,
        input  issue_ready_o, wb_valid_o, wb_reg_o, wb_data_o
    );

    modport slave (
        input  issue_valid_i, issue_op_i, issue_rnd_i, issue_rd_i,
               issue_a_i, issue_b_i, flush_i, wb_ready_i,
        output issue_ready_o, wb_valid_o, wb_reg_o, wb_data_o
    );
endinterface

// File: rtl/fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl
//   Issue/sequencing controller for the floating-point coprocessor of the
//   16-bit pipelined processor. Accepts one FP instruction at a time from EX,
//   holds its operands stable at the coprocessor inputs for the fixed
//   coprocessor latency, captures result and status, and offers them to the
//   register-file write port with a valid/ready handshake. While an operation
//   is outstanding it exposes the pending destination register to the hazard
//   unit so dependent instructions are held in ID.
//
// Parameters
//   DATA_WIDTH  operand/result width
//   REG_WIDTH   register-file address width
//   RND_WIDTH   rounding-mode field width
//   STAT_WIDTH  coprocessor status width
//   FP_LATENCY  edges from issue to a valid fpu_result_i, legal range 1..15
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active-low
//   bus (slave)   issue_valid_i/issue_ready_o/issue_op_i/issue_rnd_i/
//                 issue_rd_i/issue_a_i/issue_b_i/flush_i  (EX issue port)
//                 wb_valid_o/wb_ready_i/wb_reg_o/wb_data_o (WB write request)
//   fpu_a_o/fpu_b_o/fpu_op_o/fpu_rnd_o   held operands and controls to FPU
//   fpu_result_i/fpu_status_i            FPU result and status
//   status_o      captured FPU status, valid alongside wb_valid_o
//   rsD_i/rtD_i   source registers of the instruction in ID
//   hazard_o      ID source matches the pending FP destination
//   stall_o       issue blocked; stall PC, IF/ID and ID/EX
// -----------------------------------------------------------------------------
module fp_issue_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 8,
    parameter int FP_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    fp_issue_ctrl_if.slave        bus,

    output logic [DATA_WIDTH-1:0] fpu_a_o,
    output logic [DATA_WIDTH-1:0] fpu_b_o,
    output logic                  fpu_op_o,
    output logic [RND_WIDTH-1:0]  fpu_rnd_o,
    input  logic [DATA_WIDTH-1:0] fpu_result_i,
    input  logic [STAT_WIDTH-1:0] fpu_status_i,

    output logic [STAT_WIDTH-1:0] status_o,

    input  logic [REG_WIDTH-1:0]  rsD_i,
    input  logic [REG_WIDTH-1:0]  rtD_i,
    output logic                  hazard_o,
    output logic                  stall_o
);

    // IDLE: nothing outstanding. EXEC: FPU counting down its latency.
    // WB: result captured and waiting for the write port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Counter load value; cnt is 4 bits so FP_LATENCY must stay within 1..15.
    localparam logic [3:0] CNT_LOAD = 4'(FP_LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [REG_WIDTH-1:0]  pend_rd;

    logic                  issue_ready;
    logic                  issue_fire;
    logic                  wb_hs;
    logic                  exec_done;

    logic [REG_WIDTH-1:0]  wb_reg_q;
    logic [DATA_WIDTH-1:0] wb_data_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (issue_fire) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                // A new issue on the handshake cycle goes straight back to
                // EXEC so back-to-back FP ops lose no cycle.
                if (wb_hs) begin
                    state_nxt = issue_fire ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / control decode
    // -------------------------------------------------------------------------
    always_comb begin
        wb_hs       = (state == WB) && bus.wb_ready_i;
        issue_ready = (state == IDLE) || wb_hs;
        // Flush only suppresses this cycle's issue; it never touches an
        // operation already in EXEC or WB.
        issue_fire  = bus.issue_valid_i && issue_ready && !bus.flush_i;
        exec_done   = (state == EXEC) && (cnt == 4'd0);
        stall_o     = bus.issue_valid_i && !issue_ready && !bus.flush_i;
        // pend_rd stays meaningful through WB until the write is granted.
        hazard_o    = (state != IDLE) &&
                      ((rsD_i == pend_rd) || (rtD_i == pend_rd));
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.wb_valid_o    = (state == WB);
    assign bus.wb_reg_o      = wb_reg_q;
    assign bus.wb_data_o     = wb_data_q;

    // -------------------------------------------------------------------------
    // Datapath: latency counter, operand hold registers, result capture
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled synchronously; a reset mid-operation simply drops
    // the operation and any unwritten result because every register clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= 4'd0;
            fpu_a_o   <= '0;
            fpu_b_o   <= '0;
            fpu_op_o  <= 1'b0;
            fpu_rnd_o <= '0;
            pend_rd   <= '0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            status_o  <= '0;
        end else begin
            if (issue_fire) begin
                cnt       <= CNT_LOAD;
                fpu_a_o   <= bus.issue_a_i;
                fpu_b_o   <= bus.issue_b_i;
                fpu_op_o  <= bus.issue_op_i;
                fpu_rnd_o <= bus.issue_rnd_i;
                pend_rd   <= bus.issue_rd_i;
            end else if ((state == EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            // Capture on the edge where the FPU result becomes valid; the
            // captured values then hold through WB until the handshake.
            if (exec_done) begin
                wb_data_q <= fpu_result_i;
                status_o  <= fpu_status_i;
                wb_reg_q  <= pend_rd;
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_issue_ctrl
//   Directed bench for fp_issue_ctrl. A transaction-level model tracks the
//   outstanding operation by edge numbers (issue edge + latency = result edge)
//   and a compare process checks every DUT output against it each cycle.
//   Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fp_issue_ctrl;

    localparam int DW  = 16;
    localparam int RW  = 4;
    localparam int NW  = 3;
    localparam int SW  = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_issue_ctrl_if #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .RND_WIDTH(NW)) bus ();

    logic [DW-1:0] fpu_a, fpu_b, fpu_result;
    logic          fpu_op;
    logic [NW-1:0] fpu_rnd;
    logic [SW-1:0] fpu_status, status;
    logic [RW-1:0] rs, rt;
    logic          hazard, stall;

    fp_issue_ctrl #(
        .DATA_WIDTH(DW), .REG_WIDTH(RW), .RND_WIDTH(NW),
        .STAT_WIDTH(SW), .FP_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fpu_a_o      (fpu_a),
        .fpu_b_o      (fpu_b),
        .fpu_op_o     (fpu_op),
        .fpu_rnd_o    (fpu_rnd),
        .fpu_result_i (fpu_result),
        .fpu_status_i (fpu_status),
        .status_o     (status),
        .rsD_i        (rs),
        .rtD_i        (rt),
        .hazard_o     (hazard),
        .stall_o      (stall)
    );

    // Stub coprocessor: result and status are pure functions of the held
    // operands, so they are stable once the operands are.
    function automatic logic [15:0] fpu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic op);
        if (!op && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        return op ? (a ^ {b[7:0], b[15:8]}) : (a + b);
    endfunction

    function automatic logic [7:0] fpu_st(input logic [2:0] rnd, input logic op,
                                          input logic [15:0] a, input logic [15:0] b);
        return {rnd, op, a[3:0] ^ b[3:0]};
    endfunction

    always_comb begin
        fpu_result = fpu_fn(fpu_a, fpu_b, fpu_op);
        fpu_status = fpu_st(fpu_rnd, fpu_op, fpu_a, fpu_b);
    end

    // ---------------------------------------------------------------- checks
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------- model
    // One outstanding operation at most; it becomes a visible result at
    // issue edge + LAT and leaves on the edge where WB grants the port.
    bit          m_init = 1'b0;
    bit          m_busy, m_valid;
    bit          m_hs, m_rdy, m_fire;
    int          edge_no = 0;
    int          due_edge = 0;
    logic [15:0] m_a, m_b, m_data;
    logic        m_op;
    logic [2:0]  m_rnd;
    logic [3:0]  m_rd, m_wb_reg;
    logic [7:0]  m_status;

    task automatic model_step();
        edge_no++;
        if (!rst) begin
            m_init = 1'b1; m_busy = 1'b0; m_valid = 1'b0;
            m_a = '0; m_b = '0; m_op = 1'b0; m_rnd = '0; m_rd = '0;
            m_data = '0; m_wb_reg = '0; m_status = '0;
        end else begin
            m_hs   = m_valid && bus.wb_ready_i;
            m_rdy  = !m_busy || m_hs;
            m_fire = bus.issue_valid_i && m_rdy && !bus.flush_i;
            if (m_hs) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end else if (m_busy && !m_valid && edge_no == due_edge) begin
                m_valid  = 1'b1;
                m_data   = fpu_fn(m_a, m_b, m_op);
                m_status = fpu_st(m_rnd, m_op, m_a, m_b);
                m_wb_reg = m_rd;
            end
            if (m_fire) begin
                m_busy   = 1'b1;
                m_a      = bus.issue_a_i;
                m_b      = bus.issue_b_i;
                m_op     = bus.issue_op_i;
                m_rnd    = bus.issue_rnd_i;
                m_rd     = bus.issue_rd_i;
                due_edge = edge_no + LAT;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------------------------------------------------------- compare
    int  dut_writes = 0;
    logic exp_ready;

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            exp_ready = !m_busy || (m_valid && bus.wb_ready_i);
            check("ready",    32'(bus.issue_ready_o), 32'(exp_ready));
            check("stall",    32'(stall),
                  32'(bus.issue_valid_i && !exp_ready && !bus.flush_i));
            check("hazard",   32'(hazard), 32'(m_busy && (rs == m_rd || rt == m_rd)));
            check("wb_valid", 32'(bus.wb_valid_o), 32'(m_valid));
            check("fpu_a",    32'(fpu_a), 32'(m_a));
            check("fpu_b",    32'(fpu_b), 32'(m_b));
            check("fpu_op",   32'(fpu_op), 32'(m_op));
            check("fpu_rnd",  32'(fpu_rnd), 32'(m_rnd));
            if (m_valid) begin
                check("wb_data", 32'(bus.wb_data_o), 32'(m_data));
                check("wb_reg",  32'(bus.wb_reg_o), 32'(m_wb_reg));
                check("status",  32'(status), 32'(m_status));
            end
            if (bus.wb_valid_o && bus.wb_ready_i) dut_writes++;
        end
    end

    // ---------------------------------------------------------------- driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_issue(input logic op, input logic [2:0] rnd, input logic [3:0] rd,
                               input logic [15:0] a, input logic [15:0] b);
        bus.issue_valid_i = 1'b1;
        bus.issue_op_i    = op;
        bus.issue_rnd_i   = rnd;
        bus.issue_rd_i    = rd;
        bus.issue_a_i     = a;
        bus.issue_b_i     = b;
    endtask

    // Polls for wb_valid_o with a cycle budget; expiry counts as a failure.
    task automatic wait_valid(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wb_valid_o) begin
                got = 1'b1;
                break;
            end
            tick();
            settle();
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int w0;

    initial begin
        bus.issue_valid_i = 1'b0; bus.issue_op_i = 1'b0; bus.issue_rnd_i = '0;
        bus.issue_rd_i = '0; bus.issue_a_i = '0; bus.issue_b_i = '0;
        bus.flush_i = 1'b0; bus.wb_ready_i = 1'b0;
        rs = 4'hF; rt = 4'hF;

        // Reset state
        tick(); tick();
        rst = 1'b1;
        settle();
        check("rst wb_valid", 32'(bus.wb_valid_o), 32'd0);
        check("rst ready",    32'(bus.issue_ready_o), 32'd1);
        check("rst fpu_a",    32'(fpu_a), 32'd0);
        check("rst wb_data",  32'(bus.wb_data_o), 32'd0);
        check("rst wb_reg",   32'(bus.wb_reg_o), 32'd0);
        check("rst status",   32'(status), 32'd0);
        check("rst hazard",   32'(hazard), 32'd0);

        // 1. Latency: result visible exactly LAT edges after the issue edge
        drive_issue(1'b0, 3'b010, 4'd5, 16'h3C00, 16'h4000);
        settle();
        check("t1 ready", 32'(bus.issue_ready_o), 32'd1);
        tick();                                   // issue edge
        bus.issue_valid_i = 1'b0;
        settle();
        check("t1 fpu_a", 32'(fpu_a), 32'h3C00);
        check("t1 v+1",   32'(bus.wb_valid_o), 32'd0);
        tick(); tick();
        settle();
        check("t1 v+2",   32'(bus.wb_valid_o), 32'd0);
        tick();
        settle();
        check("t1 v+3",   32'(bus.wb_valid_o), 32'd1);
        check("t1 data",  32'(bus.wb_data_o), 32'h4200);
        check("t1 reg",   32'(bus.wb_reg_o), 32'd5);
        check("t1 stat",  32'(status), 32'h40);
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;
        settle();
        check("t1 drop",  32'(bus.wb_valid_o), 32'd0);

        // 2. Blocked issue, accepted back-to-back on the handshake cycle
        drive_issue(1'b1, 3'b000, 4'd3, 16'h1234, 16'h5678);
        tick();
        drive_issue(1'b0, 3'b001, 4'd4, 16'h1111, 16'h2222);
        settle();
        check("t2 stall", 32'(stall), 32'd1);
        check("t2 ready", 32'(bus.issue_ready_o), 32'd0);
        wait_valid("t2 wait");
        check("t2 stall wb", 32'(stall), 32'd1);
        check("t2 data",  32'(bus.wb_data_o), 32'(16'h1234 ^ 16'h7856));
        bus.wb_ready_i = 1'b1;
        settle();
        check("t2 ready hs", 32'(bus.issue_ready_o), 32'd1);
        check("t2 stall hs", 32'(stall), 32'd0);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.wb_ready_i    = 1'b0;
        settle();
        check("t2 b2b valid", 32'(bus.wb_valid_o), 32'd0);
        check("t2 b2b fpu_a", 32'(fpu_a), 32'h1111);
        check("t2 b2b ready", 32'(bus.issue_ready_o), 32'd0);

        // 3. Write-port backpressure for 4 cycles, single write on release
        wait_valid("t3 wait");
        for (int k = 0; k < 4; k++) begin
            check("t3 hold valid", 32'(bus.wb_valid_o), 32'd1);
            check("t3 hold data",  32'(bus.wb_data_o), 32'h3333);
            check("t3 hold reg",   32'(bus.wb_reg_o), 32'd4);
            check("t3 hold stat",  32'(status), 32'h23);
            tick();
            settle();
        end
        w0 = dut_writes;
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;
        settle();
        check("t3 drop", 32'(bus.wb_valid_o), 32'd0);
        tick();
        settle();
        check("t3 writes", 32'(dut_writes - w0), 32'd1);

        // 4. Dependency hazard on pending rd=7
        drive_issue(1'b0, 3'b000, 4'd7, 16'h0010, 16'h0020);
        tick();
        bus.issue_valid_i = 1'b0;
        rs = 4'd7; rt = 4'd0;
        settle();
        check("t4 rs", 32'(hazard), 32'd1);
        tick();
        rs = 4'd0; rt = 4'd7;
        settle();
        check("t4 rt", 32'(hazard), 32'd1);
        tick();
        rs = 4'd2; rt = 4'd3;
        settle();
        check("t4 none", 32'(hazard), 32'd0);
        rs = 4'd7; rt = 4'd7;
        wait_valid("t4 wait");
        check("t4 wb hazard", 32'(hazard), 32'd1);
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;
        settle();
        check("t4 after hs", 32'(hazard), 32'd0);
        rs = 4'hF; rt = 4'hF;

        // 5. Flush in IDLE does nothing; flush during EXEC does not cancel
        drive_issue(1'b1, 3'b111, 4'd9, 16'hABCD, 16'h0001);
        bus.flush_i = 1'b1;
        settle();
        check("t5 stall", 32'(stall), 32'd0);
        tick();
        settle();
        check("t5 fpu_a kept", 32'(fpu_a), 32'h0010);
        check("t5 idle ready", 32'(bus.issue_ready_o), 32'd1);
        bus.flush_i = 1'b0;
        tick();                                   // real issue
        bus.flush_i = 1'b1;                       // flush with a blocked issue
        settle();
        check("t5 exec stall", 32'(stall), 32'd0);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        settle();
        wait_valid("t5 wait");
        check("t5 data", 32'(bus.wb_data_o), 32'hAACD);
        check("t5 reg",  32'(bus.wb_reg_o), 32'd9);
        check("t5 stat", 32'(status), 32'hFC);
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;

        // 6. Reset for one edge while cnt==1
        drive_issue(1'b0, 3'b000, 4'd6, 16'h5555, 16'hAAAA);
        tick();                                   // issue edge, cnt=2
        bus.issue_valid_i = 1'b0;
        tick();                                   // cnt=1
        rst = 1'b0;
        rs  = 4'd6;
        tick();                                   // reset edge
        rst = 1'b1;
        settle();
        check("t6 valid",  32'(bus.wb_valid_o), 32'd0);
        check("t6 hazard", 32'(hazard), 32'd0);
        check("t6 ready",  32'(bus.issue_ready_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        settle();
        check("t6 stays idle", 32'(bus.wb_valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
